// File: rtl/seq_slice_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit carry-select stage is reused
// across the operand, least-significant slice first, with the carry registered between slices.
module seq_slice_adder_ctrl #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});
    localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] s_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [31:0]      shamt;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] slice_s;
    logic [SLICE:0]   sum0;
    logic [SLICE:0]   sum1;
    logic             carry_d;
    logic [WIDTH-1:0] s_d;

    // Carry-select stage: both carry-in cases are summed, the registered carry picks one.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        shamt   = 32'(idx_q) * 32'(SLICE);
        a_sl    = SLICE'(op_a_q >> shamt);
        b_sl    = SLICE'(op_b_q >> shamt);
        sum0    = {1'b0, a_sl} + {1'b0, b_sl};
        sum1    = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(1);
        {carry_d, slice_s} = carry_q ? sum1 : sum0;
        s_d     = (s_q & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_s) << shamt);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~Cin, so the borrow-in is inverted too.
                        op_a_q     <= A;
                        op_b_q     <= sub ? ~B : B;
                        carry_q    <= sub ? ~Cin : Cin;
                        idx_q      <= '0;
                        s_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;

endmodule

// File: tb/tb_seq_slice_adder_ctrl.sv
// Bench for seq_slice_adder_ctrl: three instances (SLICE = 8, 64, 1) checked against
// a plain-arithmetic model of A+B+Cin / A-B-Cin.
module tb_seq_slice_adder_ctrl;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         sb;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       in_valid = '0;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready = '0;
    logic [2:0]       cout;
    logic [2:0][W-1:0] s_o;
    logic [W-1:0]     a_i = '0;
    logic [W-1:0]     b_i = '0;
    logic             cin_i = 1'b0;
    logic             sub_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Index 0: SLICE=8, index 1: SLICE=64, index 2: SLICE=1
    seq_slice_adder_ctrl #(.WIDTH(W), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_i), .B(b_i), .Cin(cin_i), .sub(sub_i),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .S(s_o[0]), .Cout(cout[0]));

    seq_slice_adder_ctrl #(.WIDTH(W), .SLICE(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_i), .B(b_i), .Cin(cin_i), .sub(sub_i),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .S(s_o[1]), .Cout(cout[1]));

    seq_slice_adder_ctrl #(.WIDTH(W), .SLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_i), .B(b_i), .Cin(cin_i), .sub(sub_i),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .S(s_o[2]), .Cout(cout[2]));

    function automatic int nslice(input int k);
        return (k == 0) ? 8 : (k == 1) ? 1 : 64;
    endfunction

    // Returns {Cout, S}; for subtraction Cout is 1 when no borrow occurs.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sb);
        logic [W:0] r;
        if (!sb) begin
            r = {1'b0, a} + {1'b0, b} + (W + 1)'(c);
        end else begin
            r = {1'b0, a} - {1'b0, b} - (W + 1)'(c);
            r[W] = ~r[W];
        end
        return r;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sb, input logic [2:0] which);
        @(negedge clk);
        a_i = a; b_i = b; cin_i = c; sub_i = sb; in_valid = which;
        @(negedge clk);
        in_valid = '0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (out_valid[0] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || s_o[k] !== '0 || cout[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b S=%h Cout=%b, want 1 0 0 0",
                         k, in_ready[k], out_valid[k], s_o[k], cout[k]);
            end
        end
    endtask

    task automatic test_arith_vectors;
        vec_t v[5];
        int   cyc;
        v[0] = '{64'h00000000000000FF, 64'h1, 1'b0, 1'b0, 64'h0000000000000100, 1'b0};
        v[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1};
        v[2] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1};
        v[3] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0};
        v[4] = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send(v[i].a, v[i].b, v[i].c, v[i].sb, 3'b001);
            wait_done0(cyc);
            n_checks++;
            if (cyc !== 8) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d cycles, want 8", i, cyc);
            end
            n_checks++;
            if (s_o[0] !== v[i].s || cout[0] !== v[i].co) begin
                n_fail++;
                $display("FAIL vec%0d_result: S=%h Cout=%b, want S=%h Cout=%b",
                         i, s_o[0], cout[0], v[i].s, v[i].co);
            end
            release0();
            n_checks++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_return_idle: out_valid=%b in_ready=%b, want 0 1",
                         i, out_valid[0], in_ready[0]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] a1, b1;
        logic [W:0]   exp1, exp2;
        int           cyc;
        a1 = 64'h0123456789ABCDEF;
        b1 = 64'h1111111111111111;
        exp1 = model(a1, b1, 1'b1, 1'b0);
        exp2 = model(64'hFFFFFFFFFFFFFFF0, 64'h20, 1'b0, 1'b0);
        send(a1, b1, 1'b1, 1'b0, 3'b001);
        wait_done0(cyc);
        for (int i = 0; i < 5; i++) begin
            a_i = 64'hFFFFFFFFFFFFFFF0; b_i = 64'h20; cin_i = 1'b0; sub_i = 1'b0;
            in_valid[0] = 1'b1;
            n_checks++;
            if ({cout[0], s_o[0]} !== exp1 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cycle%0d: Cout,S=%h in_ready=%b out_valid=%b, want %h 0 1",
                         i, {cout[0], s_o[0]}, in_ready[0], out_valid[0], exp1);
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        n_checks++;
        if ({cout[0], s_o[0]} !== exp1 || out_valid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_accept: Cout,S=%h out_valid=%b, want %h 1",
                     {cout[0], s_o[0]}, out_valid[0], exp1);
        end
        release0();
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
        end
        send(64'hFFFFFFFFFFFFFFF0, 64'h20, 1'b0, 1'b0, 3'b001);
        wait_done0(cyc);
        n_checks++;
        if ({cout[0], s_o[0]} !== exp2 || cyc !== 8) begin
            n_fail++;
            $display("FAIL after_stall_op: Cout,S=%h cycles=%0d, want %h 8", {cout[0], s_o[0]}, cyc, exp2);
        end
        release0();
    endtask

    task automatic test_reset_mid;
        int cyc;
        send(64'h1111111111111111, 64'h1111111111111111, 1'b0, 1'b0, 3'b001);
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_o[0] !== 64'h0000000000222222 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_run: S=%h out_valid=%b, want 0000000000222222 0", s_o[0], out_valid[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || s_o[0] !== '0 || cout[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b S=%h Cout=%b, want 0 0 0", out_valid[0], s_o[0], cout[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
        end
        send(64'h1234, 64'h4321, 1'b0, 1'b0, 3'b001);
        wait_done0(cyc);
        n_checks++;
        if (s_o[0] !== 64'h5555 || cout[0] !== 1'b0 || cyc !== 8) begin
            n_fail++;
            $display("FAIL post_reset_op: S=%h Cout=%b cycles=%0d, want 5555 0 8", s_o[0], cout[0], cyc);
        end
        release0();
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         c, sb;
        logic [W:0]   exp;
        logic [2:0]   which, seen, done;
        int           cyc;
        for (int op = 0; op < 1000; op++) begin
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 7) == 0) ? ~a : {$urandom, $urandom};
            c  = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            exp = model(a, b, c, sb);
            which = (op % 4 == 0) ? 3'b111 : 3'b011;
            send(a, b, c, sb, which);
            seen = '0;
            done = ~which;
            cyc  = 0;
            while (done != 3'b111 && cyc < 400) begin
                for (int k = 0; k < 3; k++) begin
                    if (which[k] && !done[k]) begin
                        if (out_valid[k] === 1'b1) begin
                            n_checks++;
                            if ({cout[k], s_o[k]} !== exp) begin
                                n_fail++;
                                $display("FAIL rand_result op%0d dut%0d: Cout,S=%h, want %h",
                                         op, k, {cout[k], s_o[k]}, exp);
                            end
                            if (!seen[k]) begin
                                seen[k] = 1'b1;
                                n_checks++;
                                if (cyc != nslice(k)) begin
                                    n_fail++;
                                    $display("FAIL rand_latency op%0d dut%0d: got %0d cycles, want %0d",
                                             op, k, cyc, nslice(k));
                                end
                            end
                        end else if (seen[k]) begin
                            done[k] = 1'b1;
                            n_checks++;
                            if (in_ready[k] !== 1'b1) begin
                                n_fail++;
                                $display("FAIL rand_idle op%0d dut%0d: in_ready=%b, want 1", op, k, in_ready[k]);
                            end
                        end
                        out_ready[k] = ($urandom_range(0, 3) != 0);
                    end
                end
                @(negedge clk);
                cyc++;
            end
            if (done != 3'b111) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout op%0d: done=%b after %0d cycles", op, done, cyc);
                out_ready = '0;
                return;
            end
        end
        out_ready = '0;
    endtask

    initial begin
        test_reset();
        test_arith_vectors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
